// File: rtl/clb_cfg_loader.sv
// Serial configuration loader: frames a bitstream into per-CLB shadow words and
// commits them atomically to the CLB configuration bus on a clean stream.
module clb_cfg_loader #(
    parameter int NUM_CLB = 4,
    parameter int CFG_W   = 37
) (
    input  logic                       K,
    input  logic                       RSTN,
    input  logic                       DIN,
    input  logic                       DIN_VALID,
    output logic [NUM_CLB*CFG_W-1:0]   CFG_BUS,
    output logic                       CFG_LOAD,
    output logic                       CFG_DONE,
    output logic                       CFG_ERR,
    output logic                       BUSY
);

    localparam int BUS_W = NUM_CLB * CFG_W;
    localparam int CNT_W = $clog2(CFG_W + 1);

    localparam logic [CFG_W-1:0] DEF_WORD  = 37'h0380A80116;
    localparam logic [7:0]       PREAMBLE  = 8'hB2;
    localparam logic [3:0]       POSTAMBLE = 4'hA;
    localparam logic [7:0]       NUM_CLB_B = 8'(NUM_CLB);
    localparam logic [CNT_W-1:0] PAR_IDX   = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_LEN    = 3'd1,
        S_DATA   = 3'd2,
        S_POST   = 3'd3,
        S_COMMIT = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // Even parity accumulates as a running XOR; a clean frame folds to zero.
    function automatic logic par_fold(input logic par, input logic bit_in);
        return par ^ bit_in;
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         frame_q, frame_d;
    logic [7:0]         len_q, len_d;
    logic               par_q, par_d;
    logic [BUS_W-1:0]   shadow_q, shadow_d;
    logic [BUS_W-1:0]   bus_q, bus_d;
    logic               load_q, load_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic [7:0]         sr_shift_s;
    logic               shadow_cap_s;
    logic               shadow_wr_s;

    assign sr_shift_s = {sr_q[6:0], DIN};

    // Next-state and datapath control; every bit-consuming state freezes when DIN_VALID is low.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        frame_d      = frame_q;
        len_d        = len_q;
        par_d        = par_q;
        bus_d        = bus_q;
        load_d       = 1'b0;
        done_d       = done_q;
        err_d        = err_q;
        shadow_cap_s = 1'b0;
        shadow_wr_s  = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (DIN_VALID) begin
                    sr_d = sr_shift_s;
                    if (sr_shift_s == PREAMBLE) begin
                        shadow_cap_s = 1'b1;
                        done_d       = 1'b0;
                        err_d        = 1'b0;
                        cnt_d        = CNT_ZERO;
                        state_d      = S_LEN;
                    end else begin
                        state_d = S_HUNT;
                    end
                end else begin
                    state_d = S_HUNT;
                end
            end
            S_LEN: begin
                if (DIN_VALID) begin
                    sr_d = sr_shift_s;
                    if (cnt_q == CNT_W'(7)) begin
                        if ((sr_shift_s == 8'd0) || (sr_shift_s > NUM_CLB_B)) begin
                            state_d = S_ERR;
                        end else begin
                            len_d   = sr_shift_s;
                            frame_d = 8'd0;
                            cnt_d   = CNT_ZERO;
                            par_d   = 1'b0;
                            state_d = S_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (DIN_VALID) begin
                    if (cnt_q != PAR_IDX) begin
                        shadow_wr_s = 1'b1;
                        par_d       = par_fold(par_q, DIN);
                        cnt_d       = cnt_q + CNT_ONE;
                    end else if (par_fold(par_q, DIN) != 1'b0) begin
                        state_d = S_ERR;
                    end else if (frame_q == (len_q - 8'd1)) begin
                        cnt_d   = CNT_ZERO;
                        state_d = S_POST;
                    end else begin
                        frame_d = frame_q + 8'd1;
                        cnt_d   = CNT_ZERO;
                        par_d   = 1'b0;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_POST: begin
                if (DIN_VALID) begin
                    sr_d = sr_shift_s;
                    if (cnt_q == CNT_W'(3)) begin
                        if (sr_shift_s[3:0] == POSTAMBLE) begin
                            state_d = S_COMMIT;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = S_POST;
                end
            end
            S_COMMIT: begin
                bus_d   = shadow_q;
                load_d  = 1'b1;
                done_d  = 1'b1;
                sr_d    = 8'h00;
                cnt_d   = CNT_ZERO;
                state_d = S_HUNT;
            end
            S_ERR: begin
                err_d   = 1'b1;
                sr_d    = 8'h00;
                cnt_d   = CNT_ZERO;
                state_d = S_HUNT;
            end
            default: begin
                sr_d    = 8'h00;
                cnt_d   = CNT_ZERO;
                state_d = S_HUNT;
            end
        endcase

        busy_d = (state_d != S_HUNT);
    end

    // Shadow word update: snapshot the live bus at the preamble, then overwrite one bit per data bit.
    always_comb begin
        shadow_d = shadow_q;
        if (shadow_cap_s) begin
            shadow_d = bus_q;
        end else if (shadow_wr_s) begin
            for (int i = 0; i < NUM_CLB; i++) begin
                for (int k = 0; k < CFG_W; k++) begin
                    if ((frame_q == 8'(i)) && (cnt_q == CNT_W'(k))) begin
                        shadow_d[i*CFG_W + k] = DIN;
                    end else begin
                        shadow_d[i*CFG_W + k] = shadow_q[i*CFG_W + k];
                    end
                end
            end
        end else begin
            shadow_d = shadow_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge K) begin
        if (!RSTN) begin
            state_q  <= S_HUNT;
            sr_q     <= 8'h00;
            cnt_q    <= CNT_ZERO;
            frame_q  <= 8'd0;
            len_q    <= 8'd0;
            par_q    <= 1'b0;
            shadow_q <= {BUS_W{1'b0}};
            bus_q    <= {NUM_CLB{DEF_WORD}};
            load_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            len_q    <= len_d;
            par_q    <= par_d;
            shadow_q <= shadow_d;
            bus_q    <= bus_d;
            load_q   <= load_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign CFG_BUS  = bus_q;
    assign CFG_LOAD = load_q;
    assign CFG_DONE = done_q;
    assign CFG_ERR  = err_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Scoreboard bench for clb_cfg_loader: directed streams push expected commits,
// a negedge monitor pops and checks them whenever CFG_LOAD pulses.
module tb_clb_cfg_loader;

    localparam int NCLB = 4;
    localparam int W    = 37;
    localparam int BW   = NCLB * W;

    localparam logic [W-1:0]  DEF     = 37'h0380A80116;
    localparam logic [BW-1:0] DEF_BUS = {NCLB{DEF}};

    localparam logic [W-1:0] W0 = 37'h1_0000_FFFF;
    localparam logic [W-1:0] W1 = 37'h0_0000_0000;
    localparam logic [W-1:0] W2 = 37'h0_0000_0001;
    localparam logic [W-1:0] W3 = 37'h1F_FFFF_FFFF;
    localparam logic [W-1:0] P0 = 37'h0_0000_0116;
    localparam logic [W-1:0] V0 = 37'h0_1234_5678;
    localparam logic [W-1:0] V1 = 37'h1A_5A5A_5A5A;
    localparam logic [W-1:0] V2 = 37'h0_DEAD_BEEF;
    localparam logic [W-1:0] V3 = 37'h15_5555_5555;

    localparam logic [BW-1:0] FULL_BUS = {W3, W2, W1, W0};
    localparam logic [BW-1:0] PART_BUS = {W3, W2, W1, P0};
    localparam logic [BW-1:0] V_BUS    = {V3, V2, V1, V0};

    logic          K;
    logic          RSTN;
    logic          DIN;
    logic          DIN_VALID;
    logic [BW-1:0] CFG_BUS;
    logic          CFG_LOAD;
    logic          CFG_DONE;
    logic          CFG_ERR;
    logic          BUSY;

    clb_cfg_loader #(.NUM_CLB(NCLB), .CFG_W(W)) dut (
        .K(K), .RSTN(RSTN), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .CFG_BUS(CFG_BUS), .CFG_LOAD(CFG_LOAD), .CFG_DONE(CFG_DONE),
        .CFG_ERR(CFG_ERR), .BUSY(BUSY)
    );

    typedef struct {
        int            cyc;
        logic [BW-1:0] bus;
    } exp_t;

    exp_t       sb_q[$];
    logic       stream_q[$];
    logic [W-1:0] words[NCLB];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_cyc = 0;
    logic       prev_load = 1'b0;

    initial K = 1'b0;
    always #5 K = ~K;

    always @(posedge K) cyc <= cyc + 1;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every CFG_LOAD pulse must match the oldest expected commit.
    always @(negedge K) begin
        if (CFG_LOAD === 1'b1) begin
            check("load_pulse_single", BW'(prev_load), BW'(1'b0));
            check("load_expected", BW'(sb_q.size() != 0), BW'(1'b1));
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("load_cycle", BW'(cyc), BW'(e.cyc));
                check("load_bus", CFG_BUS, e.bus);
            end
        end
        prev_load <= (CFG_LOAD === 1'b1);
    end

    task automatic set_words(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d);
        words[0] = a; words[1] = b; words[2] = c; words[3] = d;
    endtask

    task automatic build(input int len, input int nframes, input int bad_frame,
                         input logic [3:0] post, input bit with_post);
        logic [7:0] pre;
        logic [7:0] lb;
        logic       p;
        pre = 8'hB2;
        lb  = 8'(len);
        stream_q.delete();
        for (int b = 7; b >= 0; b--) stream_q.push_back(pre[b]);
        for (int b = 7; b >= 0; b--) stream_q.push_back(lb[b]);
        for (int f = 0; f < nframes; f++) begin
            for (int k = 0; k < W; k++) stream_q.push_back(words[f][k]);
            p = ^words[f];
            if (f == bad_frame) p = ~p;
            stream_q.push_back(p);
        end
        if (with_post) begin
            for (int b = 3; b >= 0; b--) stream_q.push_back(post[b]);
        end
    endtask

    task automatic send(input bit gaps, input int rst_at);
        for (int i = 0; i < stream_q.size(); i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                DIN_VALID = 1'b0;
                repeat ($urandom_range(1, 7)) @(negedge K);
            end
            if (i == rst_at) begin
                RSTN      = 1'b0;
                DIN_VALID = 1'b0;
                @(negedge K);
                RSTN = 1'b1;
                break;
            end
            DIN       = stream_q[i];
            DIN_VALID = 1'b1;
            last_cyc  = cyc;
            @(negedge K);
            if (i == 7) begin
                check("preamble_err_clear", BW'(CFG_ERR), BW'(1'b0));
                check("preamble_busy", BW'(BUSY), BW'(1'b1));
            end
        end
        DIN_VALID = 1'b0;
        DIN       = 1'b0;
    endtask

    task automatic expect_commit(input logic [BW-1:0] bus);
        exp_t e;
        e.cyc = last_cyc + 2;
        e.bus = bus;
        sb_q.push_back(e);
    endtask

    task automatic status(input string tag, input logic [BW-1:0] bus,
                          input logic done, input logic err);
        repeat (4) @(negedge K);
        check({tag, "_bus"}, CFG_BUS, bus);
        check({tag, "_done"}, BW'(CFG_DONE), BW'(done));
        check({tag, "_err"}, BW'(CFG_ERR), BW'(err));
        check({tag, "_busy"}, BW'(BUSY), BW'(1'b0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN      = 1'b0;
        DIN       = 1'b0;
        DIN_VALID = 1'b0;
        repeat (2) @(negedge K);
        check("reset_bus", CFG_BUS, DEF_BUS);
        check("reset_load", BW'(CFG_LOAD), BW'(1'b0));
        check("reset_done", BW'(CFG_DONE), BW'(1'b0));
        check("reset_err", BW'(CFG_ERR), BW'(1'b0));
        check("reset_busy", BW'(BUSY), BW'(1'b0));
        RSTN = 1'b1;
        repeat (2) @(negedge K);

        // Full load of all four CLBs.
        set_words(W0, W1, W2, W3);
        build(4, 4, -1, 4'hA, 1'b1);
        send(1'b0, -1);
        expect_commit(FULL_BUS);
        status("full", FULL_BUS, 1'b1, 1'b0);

        // Partial load touches only CLB 0.
        set_words(P0, W1, W2, W3);
        build(1, 1, -1, 4'hA, 1'b1);
        send(1'b0, -1);
        expect_commit(PART_BUS);
        status("partial", PART_BUS, 1'b1, 1'b0);

        // Parity error in frame 2: no commit, bus untouched.
        set_words(W0, W1, W2, W3);
        build(4, 3, 2, 4'hA, 1'b0);
        send(1'b0, -1);
        status("badpar", PART_BUS, 1'b0, 1'b1);

        // Recovery stream clears the error at its preamble and commits.
        set_words(V0, V1, V2, V3);
        build(4, 4, -1, 4'hA, 1'b1);
        send(1'b0, -1);
        expect_commit(V_BUS);
        status("recover", V_BUS, 1'b1, 1'b0);

        // LEN beyond NUM_CLB.
        build(5, 0, -1, 4'hA, 1'b0);
        send(1'b0, -1);
        status("len5", V_BUS, 1'b0, 1'b1);

        // Wrong postamble after clean frames.
        set_words(W0, W1, W2, W3);
        build(4, 4, -1, 4'hB, 1'b1);
        send(1'b0, -1);
        status("badpost", V_BUS, 1'b0, 1'b1);

        // Full load with random DIN_VALID gaps.
        build(4, 4, -1, 4'hA, 1'b1);
        send(1'b1, -1);
        expect_commit(FULL_BUS);
        status("gapped", FULL_BUS, 1'b1, 1'b0);

        // Same stream again, reset asserted mid-frame 1.
        send(1'b1, 8 + 8 + W + 1 + 20);
        status("midreset", DEF_BUS, 1'b0, 1'b0);

        repeat (4) @(negedge K);
        check("scoreboard_empty", BW'(sb_q.size()), BW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clb_cfg_loader.md
Name: clb_cfg_loader

Overview:
- Serial configuration loader: the writer side of the CLB configuration fields.
- Receives a framed serial bitstream and assembles one configuration word per CLB into a shadow register.
- Checks framing and per-frame parity.
- On a clean stream, commits all words atomically to the parallel bus that drives the CLB configuration fields (LUT memory, mux selects, option bits).

Parameters:
- NUM_CLB, 4, number of CLBs served; valid range 1..255.
- CFG_W, 37, configuration bits per CLB; fixed by the field layout in Behaviour.

Ports:
- K, input, 1, clock, rising edge.
- RSTN, input, 1, synchronous active-low reset.
- DIN, input, 1, serial configuration data.
- DIN_VALID, input, 1, DIN is sampled on a K edge only when this is 1.
- CFG_BUS, output, NUM_CLB*CFG_W, configuration words; CLB i occupies bits [i*CFG_W +: CFG_W].
- CFG_LOAD, output, 1, one-cycle pulse on the cycle CFG_BUS updates.
- CFG_DONE, output, 1, high after a successful commit; cleared at the next preamble.
- CFG_ERR, output, 1, sticky error; cleared at the next preamble.
- BUSY, output, 1, high in any state other than HUNT.

Behaviour:
- Clock and reset: one clock K; RSTN is synchronous, active-low.
- Word layout:
  - [15:0] LUT mem
  - [17:16] comboption
  - [19:18] mux2select, [21:20] mux3select, [23:22] mux4select, [25:24] mux5select, [27:26] mux6select
  - [30:28] o2m3_0, o2m2_0, o2m1_0 (bit 28 = o2m1_0)
  - [33:31] o2m3_1, o2m2_1, o2m1_1 (bit 31 = o2m1_1)
  - [34] DQmux1, [35] DQmux2, [36] floporlatch
- Reset (RSTN=0 at a K edge):
  - Every CFG_BUS word = DEF = 37'h0380A80116.
  - CFG_LOAD=0, CFG_DONE=0, CFG_ERR=0, BUSY=0, state HUNT.
  - Shadow register and counters cleared.
  - Reset mid-stream discards the partial load.
- Stream format:
  - Preamble 8'hB2, MSB first.
  - LEN, 8 bits, MSB first.
  - LEN frames, each CFG_W data bits LSB first followed by 1 even-parity bit; XOR of all 38 bits must be 0.
  - Postamble 4'hA, MSB first.
  - Frame j targets CLB j.
- DIN_VALID=0 freezes all state, counters and shift registers; gaps of any length are allowed anywhere.
- HUNT:
  - 8-bit shift register, sr <= {sr[6:0],DIN} per valid bit.
  - When the shifted value equals 8'hB2: shadow <= CFG_BUS, CFG_DONE <= 0, CFG_ERR <= 0, go LEN.
- LEN:
  - Collect 8 bits.
  - LEN==0 or LEN>NUM_CLB: go ERR.
  - Otherwise latch LEN, frame index = 0, go DATA.
- DATA:
  - Bit counter 0..CFG_W; running XOR over the data bits.
  - Data bit k is written to shadow word [frame][k].
  - On the parity bit:
    - Mismatch: go ERR.
    - Match, last frame (index == LEN-1): go POST.
    - Match, otherwise: increment index, restart bit counter.
- POST:
  - Collect 4 bits; the comparison is made on the 4th bit.
  - Match 4'hA: go COMMIT.
  - Mismatch: go ERR.
- COMMIT (exactly one cycle):
  - CFG_BUS <= shadow, CFG_LOAD=1, CFG_DONE <= 1, go HUNT.
  - CFG_BUS and CFG_LOAD change on the edge after the edge sampling the last postamble bit.
- Words for CLBs with index >= LEN keep their prior values.
- ERR:
  - CFG_ERR <= 1, CFG_BUS unchanged, no CFG_LOAD.
  - Go HUNT on the next cycle with the preamble shift register cleared; BUSY falls.
- HUNT is the only state that searches for the preamble; a preamble pattern appearing inside data is treated as data.
- CFG_LOAD is never high for two consecutive cycles.

Test Plan:
- Reset: hold RSTN=0 for 2 cycles -> every CFG_BUS word = 37'h0380A80116; CFG_LOAD/DONE/ERR/BUSY = 0.
- Full load, NUM_CLB=4, LEN=4, words 37'h1_0000_FFFF, 0, 37'h0_0000_0001, 37'h1F_FFFF_FFFF with correct parity, postamble 4'hA:
  - CFG_LOAD pulses exactly once, one cycle after the last postamble bit.
  - CFG_BUS holds the four words; CFG_DONE=1; BUSY=0.
- Partial load, LEN=1, word 37'h0_0000_0116:
  - Word 0 updated; words 1..3 retain their previous values.
- Bad parity in frame 2 (flip the parity bit):
  - CFG_ERR=1; no CFG_LOAD; CFG_BUS unchanged.
  - A following valid stream clears CFG_ERR at its preamble and commits normally.
- LEN=5 with NUM_CLB=4 -> ERR; postamble 4'hB after valid frames -> ERR; no commit in either case.
- Same stream as the full load with random DIN_VALID=0 gaps (1-7 cycles) and RSTN=0 asserted mid-frame on a second run:
  - First run: identical result to the full load.
  - Second run: all words back to DEF, BUSY=0.
